// File: rtl/trena_tx_medida.sv
// UART 7E2 transmitter for one trena reading: sends "CDU#" as ASCII characters.
// Define TRENA_TX_CRLF_EN to append CR LF to the frame (6 characters instead of 4).
module trena_tx_medida #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       transmitir,
  input  logic [3:0] centena,
  input  logic [3:0] dezena,
  input  logic [3:0] unidade,
  output logic       saida_serial,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef TRENA_TX_CRLF_EN
  localparam int NCHAR = 6;
`else
  localparam int NCHAR = 4;
`endif
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [2:0]    CHAR_LAST = 3'(NCHAR - 1);
  localparam logic [3:0]    BIT_LAST  = 4'd10;

  typedef enum logic [3:0] {
    INICIAL   = 4'h0,
    PREPARA   = 4'h1,
    TRANSMITE = 4'h2,
    PROXIMO   = 4'h3,
    FINAL     = 4'hF
  } estado_t;

  estado_t        estado_q, estado_d;
  logic [3:0]     centena_q, centena_d;
  logic [3:0]     dezena_q, dezena_d;
  logic [3:0]     unidade_q, unidade_d;
  logic [10:0]    shift_q, shift_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     bit_q, bit_d;
  logic [2:0]     char_q, char_d;
  logic           ocupado_q, ocupado_d;
  logic           pronto_q, pronto_d;
  logic [2:0]     char_inc;

  function automatic logic [6:0] ascii_digit(input logic [3:0] d);
    return (d <= 4'd9) ? (7'h30 + {3'b000, d}) : 7'h3F;
  endfunction

  function automatic logic [6:0] char_code(input logic [2:0] idx, input logic [3:0] c,
                                           input logic [3:0] d, input logic [3:0] u);
    logic [6:0] code;
    case (idx)
      3'd0:    code = ascii_digit(c);
      3'd1:    code = ascii_digit(d);
      3'd2:    code = ascii_digit(u);
`ifdef TRENA_TX_CRLF_EN
      3'd4:    code = 7'h0D;
      3'd5:    code = 7'h0A;
`endif
      default: code = 7'h23;
    endcase
    return code;
  endfunction

  // Bit 0 goes out first: start, 7 data bits LSB first, even parity, two stops.
  function automatic logic [10:0] make_frame(input logic [6:0] ch);
    return {2'b11, ^ch, ch, 1'b0};
  endfunction

  assign char_inc = char_q + 3'd1;

  always_comb begin
    estado_d  = estado_q;
    centena_d = centena_q;
    dezena_d  = dezena_q;
    unidade_d = unidade_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    char_d    = char_q;
    ocupado_d = ocupado_q;
    pronto_d  = 1'b0;

    unique case (estado_q)
      INICIAL: begin
        ocupado_d = 1'b0;
        if (transmitir) begin
          estado_d  = PREPARA;
          centena_d = centena;
          dezena_d  = dezena;
          unidade_d = unidade;
        end
      end
      PREPARA: begin
        estado_d  = TRANSMITE;
        shift_d   = make_frame(char_code(3'd0, centena_q, dezena_q, unidade_q));
        cnt_d     = '0;
        bit_d     = '0;
        char_d    = '0;
        ocupado_d = 1'b1;
      end
      // PROXIMO is the first cycle of the next character's start bit, so no gap appears.
      TRANSMITE, PROXIMO: begin
        estado_d  = TRANSMITE;
        ocupado_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            if (char_q == CHAR_LAST) begin
              estado_d  = FINAL;
              shift_d   = '1;
              ocupado_d = 1'b0;
              pronto_d  = 1'b1;
            end else begin
              estado_d = PROXIMO;
              char_d   = char_inc;
              bit_d    = '0;
              shift_d  = make_frame(char_code(char_inc, centena_q, dezena_q, unidade_q));
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = {1'b1, shift_q[10:1]};
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FINAL: begin
        estado_d  = INICIAL;
        ocupado_d = 1'b0;
      end
      default: begin
        estado_d  = INICIAL;
        ocupado_d = 1'b0;
        shift_d   = '1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= INICIAL;
      centena_q <= '0;
      dezena_q  <= '0;
      unidade_q <= '0;
      shift_q   <= '1;
      cnt_q     <= '0;
      bit_q     <= '0;
      char_q    <= '0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      centena_q <= centena_d;
      dezena_q  <= dezena_d;
      unidade_q <= unidade_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      char_q    <= char_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
    end
  end

  assign saida_serial = shift_q[0];
  assign ocupado      = ocupado_q;
  assign pronto       = pronto_q;
  assign db_estado    = estado_q;

endmodule
